stage_if: RTL and testbench

Instruction-fetch stage of the five-stage RV32 pipeline: owns the program counter, issues instruction reads on the Wishbone-style instruction bus, and hands `{pc, instruction}` pairs to decode. It is the producer of the fetch-side exception flags that the write-back stage encodes into `mcause`. It consumes write-back's `is_exc_taken`/`mtvec` redirect, and the execute stage's branch/jump redirect.

---
 rtl/stage_if_pkg.sv | 40 ++++
 rtl/if_skid_buf.sv | 31 +++
 rtl/stage_if.sv | 162 ++++++++++++++++
 tb/tb_stage_if.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared core definitions: NOP, opcodes, mcause codes, reset PC, fetch-stage types.
// No logic; constants and types only.
// No backpressure involvement.
package stage_if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] MCAUSE_INST_MISALIGNED  = 4'd0;
    localparam logic [3:0] MCAUSE_INST_ACCESS      = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_FETCH,
        IF_DROP,
        IF_HALT
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        addr_mis;
        logic        access_fault;
    } if_pair_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched {pc, instr, flags} pair.
// Load is visible on full/dat the cycle after the edge.
// Flush beats load beats drain; the owner never loads while full and blocked.
module if_skid_buf
    import stage_if_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_vld,
    input  if_pair_t load_dat,
    input  logic     drain,
    input  logic     flush,
    output logic     full,
    output if_pair_t dat
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full <= 1'b0;
            dat  <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load_vld) begin
            full <= 1'b1;
            dat  <= load_dat;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch: owns the PC, reads the instruction bus, emits {pc, instr, flags} to decode.
// Zero-wait bus gives output valid 1 cycle after strobe; sustains 1 instr/cycle.
// Decode stall holds the output; one more word parks in the skid, then fetching pauses.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        take_branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        is_exc_taken_i,
    input  logic [31:0] mtvec_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        valid_o,
    output logic        e_inst_addr_mis_o,
    output logic        e_inst_access_fault_o
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_inc, addr_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_can_take, slot_free;
    logic        new_vld;
    if_pair_t    new_pair;
    logic        skid_full, skid_load, skid_drain;
    if_pair_t    skid_dat;
    logic        valid_q;
    if_pair_t    out_q;

    assign redirect     = is_exc_taken_i | take_branch_i;
    assign redirect_pc  = is_exc_taken_i ? mtvec_i : branch_target_i;
    assign out_can_take = !valid_q || !stall_i;
    assign slot_free    = out_can_take || !skid_full;
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        addr_d            = iwbm_addr_o;
        new_vld           = 1'b0;
        new_pair          = '0;
        new_pair.pc       = pc_q;
        new_pair.instr    = iwbm_dat_i;
        if (redirect) begin
            // An open bus cycle must still run to completion before the new target is fetched.
            pc_d = redirect_pc;
            if (state_q == IF_FETCH || state_q == IF_DROP) begin
                state_d = (iwbm_ack_i || iwbm_err_i) ? IF_IDLE : IF_DROP;
            end else begin
                state_d = IF_IDLE;
            end
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (slot_free) begin
                        if (pc_q[1:0] == 2'b00) begin
                            state_d = IF_FETCH;
                            addr_d  = pc_q;
                        end else begin
                            new_vld           = 1'b1;
                            new_pair.instr    = NOP_INSTR;
                            new_pair.addr_mis = 1'b1;
                            state_d           = IF_HALT;
                        end
                    end
                end
                IF_FETCH: begin
                    if (iwbm_err_i) begin
                        new_vld               = 1'b1;
                        new_pair.instr        = NOP_INSTR;
                        new_pair.access_fault = 1'b1;
                        state_d               = IF_HALT;
                    end else if (iwbm_ack_i) begin
                        new_vld = 1'b1;
                        pc_d    = pc_inc;
                        // Keep streaming only if this word did not have to park in the skid.
                        if (out_can_take && !skid_full) begin
                            addr_d = pc_inc;
                        end else begin
                            state_d = IF_IDLE;
                        end
                    end
                end
                IF_DROP: begin
                    if (iwbm_ack_i || iwbm_err_i) begin
                        state_d = IF_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            iwbm_addr_o <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iwbm_addr_o <= addr_d;
        end
    end

    assign iwbm_cyc_o = (state_q == IF_FETCH) || (state_q == IF_DROP);
    assign iwbm_stb_o = iwbm_cyc_o;

    assign skid_drain = skid_full && out_can_take;
    assign skid_load  = new_vld && (!out_can_take || skid_full);

    if_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_vld (skid_load),
        .load_dat (new_pair),
        .drain    (skid_drain),
        .flush    (redirect),
        .full     (skid_full),
        .dat      (skid_dat)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q            <= 1'b0;
            out_q.pc           <= '0;
            out_q.instr        <= NOP_INSTR;
            out_q.addr_mis     <= 1'b0;
            out_q.access_fault <= 1'b0;
        end else if (redirect) begin
            valid_q <= 1'b0;
        end else if (out_can_take) begin
            if (skid_full) begin
                valid_q <= 1'b1;
                out_q   <= skid_dat;
            end else if (new_vld) begin
                valid_q <= 1'b1;
                out_q   <= new_pair;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o               = valid_q;
    assign pc_o                  = out_q.pc;
    assign instruction_o         = out_q.instr;
    assign e_inst_addr_mis_o     = out_q.addr_mis;
    assign e_inst_access_fault_o = out_q.access_fault;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for the fetch stage: reset, streaming, stall/skid, redirects, exceptions.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// The bus slave is either zero-wait (acks its own strobe) or driven by hand per cycle.
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, take_branch, is_exc;
    logic [31:0] branch_target, mtvec;
    logic [31:0] addr, dat;
    logic        cyc, stb, ack, err;
    logic [31:0] pc_out, instr;
    logic        valid, mis, fault;
    logic        zw, man_ack, man_err;
    logic [31:0] man_dat;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    assign ack = zw ? stb : man_ack;
    assign err = zw ? 1'b0 : man_err;
    assign dat = zw ? mem_word(addr) : man_dat;

    stage_if dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .stall_i               (stall),
        .take_branch_i         (take_branch),
        .branch_target_i       (branch_target),
        .is_exc_taken_i        (is_exc),
        .mtvec_i               (mtvec),
        .iwbm_addr_o           (addr),
        .iwbm_cyc_o            (cyc),
        .iwbm_stb_o            (stb),
        .iwbm_dat_i            (dat),
        .iwbm_ack_i            (ack),
        .iwbm_err_i            (err),
        .pc_o                  (pc_out),
        .instruction_o         (instr),
        .valid_o               (valid),
        .e_inst_addr_mis_o     (mis),
        .e_inst_access_fault_o (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic zero_wait);
        rst_n = 1'b0; zw = zero_wait; man_ack = 1'b0; man_err = 1'b0; man_dat = '0;
        stall = 1'b0; take_branch = 1'b0; is_exc = 1'b0; branch_target = '0; mtvec = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; zw = 1'b0; man_ack = 1'b0; man_err = 1'b0; man_dat = '0;
        stall = 1'b0; take_branch = 1'b0; is_exc = 1'b0; branch_target = '0; mtvec = '0;
        step();
        step();
        checks++;
        if ({valid, cyc, stb, mis, fault} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got {valid,cyc,stb,mis,fault}=%b want 00000", {valid, cyc, stb, mis, fault});
        end
        checks++;
        if (addr !== 32'h0 || pc_out !== 32'h0 || instr !== 32'h0000_0013) begin
            failures++;
            $display("FAIL reset_data: addr=%h pc=%h instr=%h want 00000000/00000000/00000013", addr, pc_out, instr);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (stb !== 1'b1 || cyc !== 1'b1 || addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL first_fetch: cyc=%b stb=%b addr=%h want 1/1/80000000", cyc, stb, addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (stb !== 1'b1 || addr !== 32'h8000_0000 + 32'(4 * i) || valid !== (i > 0)) begin
                failures++;
                $display("FAIL stream_bus[%0d]: stb=%b addr=%h valid=%b want 1/%h/%b",
                         i, stb, addr, valid, 32'h8000_0000 + 32'(4 * i), (i > 0));
            end
            if (i > 0) begin
                exp_pc = 32'h8000_0000 + 32'(4 * (i - 1));
                checks++;
                if (pc_out !== exp_pc || instr !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL stream_out[%0d]: pc=%h instr=%h want %h/%h", i, pc_out, instr, exp_pc, mem_word(exp_pc));
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        do_reset(1'b0);
        step();
        man_ack = 1'b1; man_dat = 32'h1111_0001;
        step();
        checks++;
        if (valid !== 1'b1 || pc_out !== 32'h8000_0000 || instr !== 32'h1111_0001 || addr !== 32'h8000_0004) begin
            failures++;
            $display("FAIL skid_first: valid=%b pc=%h instr=%h addr=%h want 1/80000000/11110001/80000004", valid, pc_out, instr, addr);
        end
        stall = 1'b1; man_dat = 32'h2222_0002;
        step();
        man_ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || pc_out !== 32'h8000_0000 || instr !== 32'h1111_0001 || cyc !== 1'b0) begin
            failures++;
            $display("FAIL skid_park: valid=%b pc=%h instr=%h cyc=%b want 1/80000000/11110001/0", valid, pc_out, instr, cyc);
        end
        step();
        checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || pc_out !== 32'h8000_0000) begin
            failures++;
            $display("FAIL skid_hold: cyc=%b stb=%b pc=%h want 0/0/80000000", cyc, stb, pc_out);
        end
        stall = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || pc_out !== 32'h8000_0004 || instr !== 32'h2222_0002 || stb !== 1'b1 || addr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL skid_release: valid=%b pc=%h instr=%h stb=%b addr=%h want 1/80000004/22220002/1/80000008",
                     valid, pc_out, instr, stb, addr);
        end
        step();
        checks++;
        if (valid !== 1'b0 || stb !== 1'b1) begin
            failures++;
            $display("FAIL skid_nodup: valid=%b stb=%b want 0/1", valid, stb);
        end
        man_ack = 1'b1; man_dat = 32'h3333_0003;
        step();
        man_ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || pc_out !== 32'h8000_0008 || instr !== 32'h3333_0003) begin
            failures++;
            $display("FAIL skid_next: valid=%b pc=%h instr=%h want 1/80000008/33330003", valid, pc_out, instr);
        end
    endtask

    task automatic test_branch_drop();
        do_reset(1'b0);
        step();
        take_branch = 1'b1; branch_target = 32'h8000_0100;
        step();
        take_branch = 1'b0;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (cyc !== 1'b1 || stb !== 1'b1 || addr !== 32'h8000_0000 || valid !== 1'b0) begin
                failures++;
                $display("FAIL drop_hold[%0d]: cyc=%b stb=%b addr=%h valid=%b want 1/1/80000000/0", w, cyc, stb, addr, valid);
            end
            if (w == 0) step();
        end
        man_ack = 1'b1; man_dat = 32'hDEAD_BEEF;
        step();
        man_ack = 1'b0;
        checks++;
        if (cyc !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_discard: cyc=%b valid=%b want 0/0", cyc, valid);
        end
        step();
        checks++;
        if (stb !== 1'b1 || addr !== 32'h8000_0100 || valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_retarget: stb=%b addr=%h valid=%b want 1/80000100/0", stb, addr, valid);
        end
        man_ack = 1'b1; man_dat = 32'h4444_0004;
        step();
        man_ack = 1'b0;
        checks++;
        if (valid !== 1'b1 || pc_out !== 32'h8000_0100 || instr !== 32'h4444_0004) begin
            failures++;
            $display("FAIL drop_newword: valid=%b pc=%h instr=%h want 1/80000100/44440004", valid, pc_out, instr);
        end
    endtask

    task automatic test_exc_priority();
        do_reset(1'b0);
        step();
        take_branch = 1'b1; branch_target = 32'h8000_0200;
        is_exc = 1'b1; mtvec = 32'h8000_0040;
        man_ack = 1'b1; man_dat = 32'h5555_0005;
        step();
        take_branch = 1'b0; is_exc = 1'b0; man_ack = 1'b0;
        checks++;
        if (cyc !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_discard: cyc=%b valid=%b want 0/0", cyc, valid);
        end
        step();
        checks++;
        if (stb !== 1'b1 || addr !== 32'h8000_0040) begin
            failures++;
            $display("FAIL prio_target: stb=%b addr=%h want 1/80000040", stb, addr);
        end
    endtask

    task automatic test_misaligned();
        do_reset(1'b0);
        step();
        take_branch = 1'b1; branch_target = 32'h8000_0102;
        man_ack = 1'b1; man_dat = 32'h6666_0006;
        step();
        take_branch = 1'b0; man_ack = 1'b0;
        step();
        checks++;
        if (valid !== 1'b1 || mis !== 1'b1 || fault !== 1'b0 || instr !== 32'h0000_0013 ||
            pc_out !== 32'h8000_0102 || cyc !== 1'b0) begin
            failures++;
            $display("FAIL mis_pair: valid=%b mis=%b fault=%b instr=%h pc=%h cyc=%b want 1/1/0/00000013/80000102/0",
                     valid, mis, fault, instr, pc_out, cyc);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (cyc !== 1'b0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL mis_halt[%0d]: cyc=%b valid=%b want 0/0", k, cyc, valid);
            end
        end
        is_exc = 1'b1; mtvec = 32'h8000_0040;
        step();
        is_exc = 1'b0;
        step();
        checks++;
        if (stb !== 1'b1 || addr !== 32'h8000_0040) begin
            failures++;
            $display("FAIL mis_resume: stb=%b addr=%h want 1/80000040", stb, addr);
        end
    endtask

    task automatic test_access_fault();
        do_reset(1'b0);
        step();
        man_ack = 1'b1; man_dat = 32'h7777_0007;
        step();
        step();
        man_ack = 1'b0;
        checks++;
        if (stb !== 1'b1 || addr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL fault_addr: stb=%b addr=%h want 1/80000008", stb, addr);
        end
        man_ack = 1'b1; man_err = 1'b1;
        step();
        man_ack = 1'b0; man_err = 1'b0;
        checks++;
        if (valid !== 1'b1 || fault !== 1'b1 || mis !== 1'b0 || instr !== 32'h0000_0013 ||
            pc_out !== 32'h8000_0008 || cyc !== 1'b0) begin
            failures++;
            $display("FAIL fault_pair: valid=%b fault=%b mis=%b instr=%h pc=%h cyc=%b want 1/1/0/00000013/80000008/0",
                     valid, fault, mis, instr, pc_out, cyc);
        end
        step();
        checks++;
        if (cyc !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_halt: cyc=%b valid=%b want 0/0", cyc, valid);
        end
        is_exc = 1'b1; mtvec = 32'h8000_0040;
        step();
        is_exc = 1'b0;
        step();
        checks++;
        if (cyc !== 1'b1 || addr !== 32'h8000_0040) begin
            failures++;
            $display("FAIL fault_resume: cyc=%b addr=%h want 1/80000040", cyc, addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: cyc=%b stb=%b addr=%h want 0/0/00000000", cyc, stb, addr);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_branch_drop();
        test_exc_priority();
        test_misaligned();
        test_access_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
